// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the RSA stream controller and the
// rsa_encoder/rsa_decoder cores it sequences.
package rsa_pkg;

  localparam int                N_BIT = 12;
  localparam logic [N_BIT-1:0]  N     = 12'd3551;

  // Montgomery constants the cores are built around (R = 2^LOGR words).
  localparam int                LOGR   = 3;
  localparam int                P      = 1;
  localparam logic [N_BIT-1:0]  RMODN  = 12'd545;
  localparam logic [N_BIT-1:0]  R2MODN = 12'd2292;
  localparam logic [N_BIT-1:0]  E      = 12'd5;
  localparam logic [N_BIT-1:0]  D      = 12'd1373;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/rsa_out_slot.sv
// Single-entry output register on a valid/ready stream; a capture in the
// same cycle as a drain wins and keeps the slot full with the new word.
module rsa_out_slot
  import rsa_pkg::*;
#(
  parameter int W = N_BIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap_i,
  input  logic [W-1:0] cap_data_i,
  input  logic         out_ready_i,
  output logic         free_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (cap_i) begin
      valid_d = 1'b1;
      data_d  = cap_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign free_o      = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Stream front end for one rsa_encoder/rsa_decoder core: range-checks input
// words, drives the core's level start/done handshake and buffers the result.
// Optional per-instance counters cnt_ok/cnt_rej when RSA_STREAM_CNT_EN is defined.
module rsa_stream_ctrl
  import rsa_pkg::*;
#(
  parameter int               n_bit = N_BIT,
  parameter logic [n_bit-1:0] n     = N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n_bit-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n_bit-1:0] out_data,
  output logic             err_range,
  output logic             core_start,
  output logic [n_bit-1:0] core_data,
  input  logic             core_done,
  input  logic [n_bit-1:0] core_result
`ifdef RSA_STREAM_CNT_EN
  ,
  output logic [31:0]      cnt_ok,
  output logic [31:0]      cnt_rej
`endif
);

  state_e           state_q;
  logic             core_start_q;
  logic             err_range_q;
  logic [n_bit-1:0] core_data_q;

  logic accept;
  logic in_range;
  logic capture;
  logic slot_free;

  // A done still high from the previous job (or a misbehaving core) blocks input.
  assign in_ready = rst_n & (state_q == IDLE) & ~core_done;
  assign accept   = in_valid & in_ready;
  assign in_range = (in_data < n);
  assign capture  = (state_q == RUN) & core_done & slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      core_start_q <= 1'b0;
      err_range_q  <= 1'b0;
      core_data_q  <= '0;
    end else begin
      err_range_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              core_data_q <= in_data;
              state_q     <= SETUP;
            end else begin
              err_range_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          core_start_q <= 1'b1;
          state_q      <= RUN;
        end
        RUN: begin
          // With the slot full and not draining, start stays high and the core holds done.
          if (capture) begin
            core_start_q <= 1'b0;
            state_q      <= CLEAR;
          end
        end
        CLEAR: begin
          if (!core_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_data  = core_data_q;
  assign err_range  = err_range_q;

  rsa_out_slot #(
    .W (n_bit)
  ) u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_i       (capture),
    .cap_data_i  (core_result),
    .out_ready_i (out_ready),
    .free_o      (slot_free),
    .out_valid_o (out_valid),
    .out_data_o  (out_data)
  );

`ifdef RSA_STREAM_CNT_EN
  logic [31:0] cnt_ok_q;
  logic [31:0] cnt_rej_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_rej_q <= '0;
    end else begin
      if (capture)     cnt_ok_q  <= cnt_ok_q + 32'd1;
      if (err_range_q) cnt_rej_q <= cnt_rej_q + 32'd1;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_rej = cnt_rej_q;
`endif

endmodule

// File: doc/rsa_stream_ctrl.md
Name: rsa_stream_ctrl

Overview:
- Upstream sequencer for the rsa_encoder/rsa_decoder cores.
- Accepts plaintext (or ciphertext) words on a valid/ready stream and range-checks each against the modulus.
- Runs each word through one core using the core's level start/done protocol, then presents the result on an output valid/ready stream.
- Replaces hand-driven start/done sequencing with a reusable datapath front end; one instance per core.

Parameters:
- n, 12'd3551, RSA modulus; inputs >= n are rejected.
- n_bit, 12, word width of data and modulus.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  n_bit  input word.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  n_bit  core result.
- err_range  out  1  one-cycle pulse: the accepted word was >= n and was dropped.
- core_start  out  1  level start to core; held high until done.
- core_data  out  n_bit  operand to the core data_in; stable while core_start=1.
- core_done  in  1  core done level.
- core_result  in  n_bit  core data_out; valid while core_done=1.

Behaviour:
- Reset: async, active-low; all outputs 0; state IDLE; output slot empty.
- Reset mid-operation forces core_start=0, which aborts the core. Results in flight are lost and no err_range is generated.
- Handshakes: transfer occurs when valid and ready are both high on a rising edge. in_valid/in_data must hold until accepted. out_data stays stable while out_valid=1 and out_ready=0.
- in_ready=1 only in IDLE and only when core_done=0.
- FSM states:
  - IDLE: on an in_valid transfer with in_data < n, latch in_data into core_data and go to SETUP. On a transfer with in_data >= n, pulse err_range the next cycle and stay in IDLE. core_data is unchanged and core_start is not raised.
  - SETUP: exactly 1 cycle with core_start=0 and core_data stable (operand setup); go to RUN.
  - RUN: core_start=1. When core_done=1 and the output slot is empty, or is being emptied this cycle (out_valid & out_ready), capture core_result into out_data, set out_valid=1 next cycle, and go to CLEAR. If the slot is full and not draining, stay in RUN with core_start held high; the core holds done.
  - CLEAR: core_start=0; wait until core_done=0, then go to IDLE.
- Output slot: a single register. out_valid clears on an out_ready transfer unless a new capture happens in the same cycle, in which case it stays set with the new data.
- Timing with an always-ready sink: input accepted at cycle 0; core_start rises at cycle 2; out_valid rises 1 cycle after core_done is first seen high.
- Throughput: one word in flight; the next word is accepted in the cycle after core_done falls.
- Width: the comparison in_data < n is unsigned at n_bit. No arithmetic on data.
- core_done=1 in IDLE or SETUP is a protocol violation: it is ignored and input is blocked via in_ready.

Optional Feature:
- Macro: RSA_STREAM_CNT_EN.
- Defined: adds outputs cnt_ok [31:0] and cnt_rej [31:0].
  - cnt_ok increments on each result capture.
  - cnt_rej increments on each err_range pulse.
  - Both wrap from 2^32-1 to 0 and reset to 0.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rsa_pkg holds:
  - default N=3551, N_BIT=12, and the Montgomery constants shared with the cores (logr=3, p=1, Rmodn=545, R2modn=2292, e=5, d=1373);
  - the FSM state encoding IDLE/SETUP/RUN/CLEAR.
- Sub-module rsa_out_slot: the single-entry output register with valid/ready and capture-priority logic.

Test Plan:
- Bench setup for all scenarios: rsa_encoder with e=5, n=3551 attached to the core ports.
- Basic: in_data=2 with sink always ready -> out_data=32, err_range=0, core_start high from 2 cycles after acceptance until done.
- Stream: inputs 3, then 10, back-to-back -> outputs 243 then 572 in order; in_ready=0 while a word is in flight.
- Range: in_data=3551, then 4095 -> two err_range pulses, no core_start, no out_valid; next input 2 -> 32.
- Backpressure:
  - hold out_ready=0 after the first result -> out_data stays 32 and core_start stays high on the second job until out_ready=1;
  - the second result (243) then follows.
- Reset mid-RUN: rst_n low for 1 cycle -> core_start=0 and out_valid=0 immediately; a subsequent input 2 -> 32.
- Round trip: encoder instance feeding a decoder instance (d=1373), inputs 0..3550 -> every decoder output equals its input.
